riscv_mem_arbiter: RTL
======================

# riscv_mem_arbiter

Arbitrates single-port access to the SoC instruction/data memory between three requesters: the debug loader, the CPU load/store unit and the CPU instruction fetch. It sits between `riscv_cpu` and the memory slave (rom/ram) inside `riscv_soc`. It serialises transactions with a req/gnt/rvalid handshake and keeps one transaction outstanding at a time. An optional watchdog terminates hung slave accesses.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT, 16, watchdog limit in cycles, ≥2; used only with the timeout feature
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- mN_req  in  1  request; N=0 debug, N=1 lsu, N=2 ifetch; held with payload until gnt
- mN_we  in  1  1=write, 0=read
- mN_addr  in  ADDR_W  address
- mN_wdata  in  DATA_W  write data
- mN_gnt  out  1  one-cycle pulse: request accepted, payload may change
- mN_rvalid  out  1  one-cycle pulse: transaction complete
- mN_rdata  out  DATA_W  read data, valid with rvalid; 0 for writes
- mN_rerr  out  1  error flag, valid with rvalid
- s_req  out  1  slave request, held until s_ack
- s_we  out  1  latched we
- s_addr  out  ADDR_W  latched address
- s_wdata  out  DATA_W  latched write data
- s_ack  in  1  slave completion; may assert in the first s_req cycle
- s_rdata  in  DATA_W  slave read data, valid with s_ack
- busy  out  1  high while not IDLE

## Operation
- FSM states are IDLE, ACCESS and RESP.
- IDLE: when any mN_req is high, select a winner, latch its we/addr/wdata and index, then go to ACCESS. Assert mN_gnt for that master.
- Priority: m0 always wins. m1 and m2 are round-robin: if both request, the one not served last wins.
  - rr pointer updates only when m1 or m2 is granted.
  - Reset value of the pointer favours m1.
- ACCESS: s_req=1 with latched payload. On s_ack, capture s_rdata (or 0 if write), then go to RESP.
- RESP: pulse rvalid/rdata/rerr to the latched master, then go to IDLE.
- Requests that arrive while not IDLE wait; they are never dropped.
- Reset values: all outputs 0; FSM=IDLE; rr pointer favours m1; watchdog counter=0.
- Reset mid-transaction: s_req drops at the reset edge, and no rvalid is issued for the abandoned transaction. An s_ack arriving while in IDLE is ignored.

## Timing
- Request sampled high at edge N (state IDLE): at N+1, mN_gnt=1 for one cycle, s_req=1 and state=ACCESS.
- s_ack sampled at edge M, where M ≥ N+1: at M+1, state=RESP, mN_rvalid=1 and rdata registered; s_req=0.
- At M+2, state=IDLE and the next arbitration is sampled; the next gnt/s_req follows at M+3.
- Minimum request-to-rvalid latency is 2 cycles (s_ack in the first ACCESS cycle). Sustained throughput is 1 transaction per 3 cycles.
- gnt and rvalid are never asserted in the same cycle for the same master.
- The master must keep mN_req low after gnt unless it issues a new request. A req still high at the next IDLE is treated as a new request.

## Configuration
- MEM_ARB_TIMEOUT_EN defined:
  - A counter resets at entry to ACCESS and increments each ACCESS cycle without s_ack.
  - On reaching TIMEOUT-1 without s_ack: go to RESP with rerr=1 and rdata=0, and drop s_req.
  - An s_ack in the same cycle as the timeout wins: normal completion, rerr=0.
- Not defined: ACCESS waits indefinitely, and all mN_rerr are tied to 0. Ports are identical in both builds.

## Test plan
- Single read: m2_req, addr 0x10; slave acks in the first cycle with 0x00A00093. Required: m2_gnt 1 cycle after req, m2_rvalid 2 cycles after req with rdata 0x00A00093, rerr=0.
- Contention: m0, m1 and m2 request in the same cycle; the slave acks immediately each time. Required grant order is m0, m1, m2, with rvalids 3 cycles apart.
- Round-robin: m1 and m2 both request continuously for 4 transactions. Required grant order is m1, m2, m1, m2.
- Write plus slow slave: m1 writes 0x5 to 0x20, and the slave acks after 5 cycles. Required: s_we=1, s_addr=0x20, s_wdata=0x5 held stable for 5 cycles; m1_rvalid with rdata=0.
- Reset mid-access: rst asserted for 1 cycle while in ACCESS. Required: s_req=0 and busy=0 the next cycle, no rvalid for that transaction, and a following late s_ack is ignored.
- Timeout (with MEM_ARB_TIMEOUT_EN, TIMEOUT=16): the slave never acks m0's read. Required: s_req held for 15 cycles, then m0_rvalid=1, m0_rerr=1, rdata=0, and a return to IDLE.

Source files
------------

// File: rtl/riscv_mem_arbiter_if.sv
// Bus bundle between the three memory requesters, the arbiter and the memory slave.
// The slave modport is the arbiter's view; master is the surrounding SoC/bench view.
interface riscv_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              m0_req, m0_we, m0_gnt, m0_rvalid, m0_rerr;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wdata, m0_rdata;
  logic              m1_req, m1_we, m1_gnt, m1_rvalid, m1_rerr;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata, m1_rdata;
  logic              m2_req, m2_we, m2_gnt, m2_rvalid, m2_rerr;
  logic [ADDR_W-1:0] m2_addr;
  logic [DATA_W-1:0] m2_wdata, m2_rdata;
  logic              s_req, s_we, s_ack;
  logic [ADDR_W-1:0] s_addr;
  logic [DATA_W-1:0] s_wdata, s_rdata;
  logic              busy;

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    input  m2_req, m2_we, m2_addr, m2_wdata,
    output m0_gnt, m0_rvalid, m0_rdata, m0_rerr,
    output m1_gnt, m1_rvalid, m1_rdata, m1_rerr,
    output m2_gnt, m2_rvalid, m2_rdata, m2_rerr,
    output s_req, s_we, s_addr, s_wdata, busy,
    input  s_ack, s_rdata
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    output m1_req, m1_we, m1_addr, m1_wdata,
    output m2_req, m2_we, m2_addr, m2_wdata,
    input  m0_gnt, m0_rvalid, m0_rdata, m0_rerr,
    input  m1_gnt, m1_rvalid, m1_rdata, m1_rerr,
    input  m2_gnt, m2_rvalid, m2_rdata, m2_rerr,
    input  s_req, s_we, s_addr, s_wdata, busy,
    output s_ack, s_rdata
  );
endinterface

// File: rtl/riscv_mem_arbiter.sv
// Three-way single-outstanding memory arbiter: m0 fixed priority, m1/m2 round-robin.
// Define MEM_ARB_TIMEOUT_EN to add a watchdog that ends hung slave accesses with rerr.
module riscv_mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input logic                clk,
  input logic                rst,
  riscv_mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  if (TIMEOUT < 2) begin : g_bad_timeout
    $error("riscv_mem_arbiter: TIMEOUT must be >= 2");
  end

  state_t            state_q, state_d;
  logic [2:0]        req;
  logic              we_v    [3];
  logic [ADDR_W-1:0] addr_v  [3];
  logic [DATA_W-1:0] wdata_v [3];
  logic [1:0]        win;
  logic [1:0]        idx_q;
  logic [2:0]        gnt_q, rvalid;
  logic              rr_last_m2_q;  // 1: m2 was the last of m1/m2 served, so m1 wins a tie
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, rdata_q;
  logic              rerr_q;
  logic              timeout_hit;

  assign req        = {bus.m2_req, bus.m1_req, bus.m0_req};
  assign we_v[0]    = bus.m0_we;
  assign we_v[1]    = bus.m1_we;
  assign we_v[2]    = bus.m2_we;
  assign addr_v[0]  = bus.m0_addr;
  assign addr_v[1]  = bus.m1_addr;
  assign addr_v[2]  = bus.m2_addr;
  assign wdata_v[0] = bus.m0_wdata;
  assign wdata_v[1] = bus.m1_wdata;
  assign wdata_v[2] = bus.m2_wdata;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    win = 2'd0;
    if (req[0])                win = 2'd0;
    else if (req[1] && req[2]) win = rr_last_m2_q ? 2'd1 : 2'd2;
    else if (req[1])           win = 2'd1;
    else if (req[2])           win = 2'd2;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (|req) state_d = ACCESS;
      ACCESS:  if (bus.s_ack || timeout_hit) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: the latched payload is reset too, because it drives s_* outputs directly.
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_q        <= '0;
      idx_q        <= 2'd0;
      rr_last_m2_q <= 1'b1;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
    end else begin
      gnt_q <= '0;
      if (state_q == IDLE && |req) begin
        gnt_q   <= 3'b001 << win;
        idx_q   <= win;
        we_q    <= we_v[win];
        addr_q  <= addr_v[win];
        wdata_q <= wdata_v[win];
        if (win != 2'd0) rr_last_m2_q <= (win == 2'd2);
      end
      if (state_q == ACCESS) begin
        if (bus.s_ack)        rdata_q <= we_q ? '0 : bus.s_rdata;
        else if (timeout_hit) rdata_q <= '0;
      end
    end
  end

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  logic [CNT_W-1:0] cnt_q;

  // The counter reaches TIMEOUT-1 on the same edge that leaves ACCESS.
  assign timeout_hit = (state_q == ACCESS) && !bus.s_ack && (cnt_q == CNT_W'(TIMEOUT - 2));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      rerr_q <= 1'b0;
    end else begin
      if (state_q == IDLE) cnt_q <= '0;
      else if (state_q == ACCESS && !bus.s_ack) cnt_q <= cnt_q + 1'b1;
      if (state_q == ACCESS && (bus.s_ack || timeout_hit)) rerr_q <= timeout_hit;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign rerr_q      = 1'b0;
`endif

  assign rvalid = (state_q == RESP) ? (3'b001 << idx_q) : 3'b000;

  assign bus.m0_gnt    = gnt_q[0];
  assign bus.m1_gnt    = gnt_q[1];
  assign bus.m2_gnt    = gnt_q[2];
  assign bus.m0_rvalid = rvalid[0];
  assign bus.m1_rvalid = rvalid[1];
  assign bus.m2_rvalid = rvalid[2];
  assign bus.m0_rdata  = rvalid[0] ? rdata_q : '0;
  assign bus.m1_rdata  = rvalid[1] ? rdata_q : '0;
  assign bus.m2_rdata  = rvalid[2] ? rdata_q : '0;
  assign bus.m0_rerr   = rvalid[0] & rerr_q;
  assign bus.m1_rerr   = rvalid[1] & rerr_q;
  assign bus.m2_rerr   = rvalid[2] & rerr_q;

  assign bus.s_req   = (state_q == ACCESS);
  assign bus.s_we    = we_q;
  assign bus.s_addr  = addr_q;
  assign bus.s_wdata = wdata_q;
  assign bus.busy    = (state_q != IDLE);

endmodule
